// File: rtl/fpu_operand_driver.sv
// Initiator for the FPU stb/ack protocol. It sends operand A, then operand B, collects Z and buffers the results in a FIFO.
// Optional build macro FPU_DRV_TIMEOUT_EN: adds a WAIT_Z watchdog, an fpu_rst pulse and error-tagged results.
module fpu_operand_driver #(
    parameter int RES_DEPTH = 4
`ifdef FPU_DRV_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 1024
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_a,
    input  logic [31:0] cmd_b,
    input  logic [1:0]  cmd_op,
    output logic [31:0] input_a,
    output logic        input_a_stb,
    input  logic        input_a_ack,
    output logic [31:0] input_b,
    output logic        input_b_stb,
    input  logic        input_b_ack,
    output logic [1:0]  op_sel,
    input  logic [31:0] output_z,
    input  logic        output_z_stb,
    output logic        output_z_ack,
    output logic [31:0] res_data,
    output logic        res_valid,
    input  logic        res_ready,
    output logic        res_err,
`ifdef FPU_DRV_TIMEOUT_EN
    output logic        fpu_rst,
`endif
    output logic        busy
);
    localparam int AW = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(RES_DEPTH);
`ifdef FPU_DRV_TIMEOUT_EN
    localparam int EW = 33;
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0] ABORT_NAN = 32'h7FC0_0000;
`else
    localparam int EW = 32;
`endif

    typedef enum logic [1:0] {IDLE, SEND_A, SEND_B, WAIT_Z} state_e;

    state_e        state_q, state_d;
    logic [31:0]   input_a_q, input_a_d;
    logic [31:0]   input_b_q, input_b_d;
    logic [1:0]    op_sel_q, op_sel_d;
    logic          a_stb_q, a_stb_d;
    logic          b_stb_q, b_stb_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [EW-1:0] mem_q [RES_DEPTH];
    logic [EW-1:0] push_entry;
    logic          push, pop, z_ack;
`ifdef FPU_DRV_TIMEOUT_EN
    logic [15:0]   timer_q, timer_d;
    logic          fpu_rst_q, fpu_rst_d;
`endif

    assign cmd_ready = (state_q == IDLE) && (count_q != FULL_CNT);
    assign pop       = (count_q != '0) && res_ready;

    // NOTE: every comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        input_a_d  = input_a_q;
        input_b_d  = input_b_q;
        op_sel_d   = op_sel_q;
        a_stb_d    = a_stb_q;
        b_stb_d    = b_stb_q;
        push       = 1'b0;
        push_entry = EW'(output_z);
        z_ack      = 1'b0;
`ifdef FPU_DRV_TIMEOUT_EN
        timer_d    = timer_q;
        fpu_rst_d  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    input_a_d = cmd_a;
                    input_b_d = cmd_b;
                    op_sel_d  = cmd_op;
                    a_stb_d   = 1'b1;
                    state_d   = SEND_A;
                end
            end
            SEND_A: begin
                if (a_stb_q && input_a_ack) begin
                    a_stb_d = 1'b0;
                    b_stb_d = 1'b1;
                    state_d = SEND_B;
                end
            end
            SEND_B: begin
                if (b_stb_q && input_b_ack) begin
                    b_stb_d = 1'b0;
`ifdef FPU_DRV_TIMEOUT_EN
                    timer_d = '0;
`endif
                    state_d = WAIT_Z;
                end
            end
            WAIT_Z: begin
                // The ack is combinational, so the transfer and the push happen in the same cycle.
                if (output_z_stb) begin
                    z_ack   = 1'b1;
                    push    = 1'b1;
                    state_d = IDLE;
                end
`ifdef FPU_DRV_TIMEOUT_EN
                else if (timer_q == TO_LAST) begin
                    push       = 1'b1;
                    push_entry = {1'b1, ABORT_NAN};
                    fpu_rst_d  = 1'b1;
                    state_d    = IDLE;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments, so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            input_a_q <= '0;
            input_b_q <= '0;
            op_sel_q  <= '0;
            a_stb_q   <= 1'b0;
            b_stb_q   <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            input_a_q <= input_a_d;
            input_b_q <= input_b_d;
            op_sel_q  <= op_sel_d;
            a_stb_q   <= a_stb_d;
            b_stb_q   <= b_stb_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
        end
    end

    // NOTE: the storage array has no reset; count_q alone determines which entries are valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= push_entry;
    end

`ifdef FPU_DRV_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            timer_q   <= '0;
            fpu_rst_q <= 1'b0;
        end else begin
            timer_q   <= timer_d;
            fpu_rst_q <= fpu_rst_d;
        end
    end

    assign fpu_rst = fpu_rst_q;
    assign res_err = mem_q[rd_ptr_q][EW-1];
`else
    assign res_err = 1'b0;
`endif

    assign input_a      = input_a_q;
    assign input_b      = input_b_q;
    assign op_sel       = op_sel_q;
    assign input_a_stb  = a_stb_q;
    assign input_b_stb  = b_stb_q;
    assign output_z_ack = z_ack;
    assign res_data     = mem_q[rd_ptr_q][31:0];
    assign res_valid    = (count_q != '0);
    assign busy         = (state_q != IDLE);
endmodule
